timer_dev: RTL and testbench

Memory-mapped programmable down-counter timer on the system bus, downstream of the CPU datapath's memory stage. The system bridge decodes the core's M-stage address and store enable into this block and returns its read data on the processor read-data path. The timer's interrupt output drives hardware interrupt line HWInt[0] of the core. It supports one-shot mode with a latched interrupt and auto-reload mode with a periodic one-cycle interrupt pulse.

---
 rtl/timer_dev.sv | 110 +++++++++++
 tb/tb_timer_dev.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// Memory-mapped 32-bit down-counter timer with one-shot and auto-reload modes.
// The interrupt is IM-masked, and the pending flag is cleared by any CTRL write.
module timer_dev (
    input  logic        clk,
    input  logic        clr,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_pending;

    logic w_en;
    logic w_auto;
    logic w_zero;
    logic w_ctrl_wr;
    logic w_preset_wr;

    assign w_en        = r_ctrl[0];
    assign w_auto      = (r_ctrl[2:1] == 2'b01);
    assign w_zero      = (r_count == 32'd0);
    assign w_ctrl_wr   = we && (addr == 2'd0);
    assign w_preset_wr = we && (addr == 2'd1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_en) w_next = S_LOAD;
            S_LOAD:  w_next = S_CNT;
            S_CNT: begin
                if (!w_en)
                    w_next = S_IDLE;
                else if (w_zero)
                    w_next = S_INT;
            end
            S_INT:   w_next = w_auto ? S_LOAD : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // The CPU CTRL write is placed last so it overrides the hardware EN clear
    // and the pending set/clear on the same edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_ctrl    <= 4'd0;
            r_preset  <= 32'd0;
            r_count   <= 32'd0;
            r_pending <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: r_count <= r_preset;
                S_CNT: begin
                    if (w_en) begin
                        if (w_zero)
                            r_pending <= 1'b1;
                        else
                            r_count <= r_count - 32'd1;
                    end
                end
                S_INT: begin
                    if (w_auto)
                        r_pending <= 1'b0;
                    else
                        r_ctrl[0] <= 1'b0;
                end
                default: ;
            endcase
            if (w_ctrl_wr) begin
                r_ctrl    <= wdata[3:0];
                r_pending <= 1'b0;
            end
            if (w_preset_wr)
                r_preset <= wdata;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            2'd0:    rdata = {28'd0, r_ctrl};
            2'd1:    rdata = r_preset;
            2'd2:    rdata = r_count;
            default: rdata = 32'd0;
        endcase
    end

    assign irq = r_ctrl[3] & r_pending;

endmodule

// File: tb/tb_timer_dev.sv
// Bench for timer_dev: directed scenarios followed by random bus traffic.
// All results are compared against a timeline reference model.
module tb_timer_dev;

    logic        clk = 1'b0;
    logic        clr;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    timer_dev dut (
        .clk   (clk),
        .clr   (clr),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // Reference model. A period is described by the edge index of its load
    // (m_tl) and the loaded preset (m_lp). The count reaches zero at
    // m_tl+m_lp, pending sets at m_tl+m_lp+1, and the interrupt edge is m_tl+m_lp+2.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_pend;
    logic        m_run;
    longint      m_t;
    longint      m_tl;
    longint      m_lp;

    task automatic model_reset();
        m_ctrl   = 4'd0;
        m_preset = 32'd0;
        m_count  = 32'd0;
        m_pend   = 1'b0;
        m_run    = 1'b0;
        m_t      = 0;
        m_tl     = 0;
        m_lp     = 0;
    endtask

    task automatic model_edge(input logic w, input logic [1:0] a, input logic [31:0] d);
        logic en;
        logic auto_m;
        en     = m_ctrl[0];
        auto_m = (m_ctrl[2:1] == 2'b01);
        m_t    = m_t + 1;
        if (!m_run) begin
            if (en) begin
                m_run = 1'b1;
                m_tl  = m_t + 1;
            end
        end else if (m_t == m_tl) begin
            m_count = m_preset;
            m_lp    = longint'(m_preset);
        end else if (m_t <= m_tl + m_lp) begin
            if (!en) m_run = 1'b0;
            else     m_count = m_count - 32'd1;
        end else if (m_t == m_tl + m_lp + 1) begin
            if (!en) m_run = 1'b0;
            else     m_pend = 1'b1;
        end else begin
            if (auto_m) begin
                m_pend = 1'b0;
                m_tl   = m_t + 1;
            end else begin
                m_ctrl[0] = 1'b0;
                m_run     = 1'b0;
            end
        end
        if (w && a == 2'd0) begin
            m_ctrl = d[3:0];
            m_pend = 1'b0;
        end
        if (w && a == 2'd1)
            m_preset = d;
    endtask

    function automatic logic [31:0] exp_rd(input int a);
        case (a)
            0:       return {28'd0, m_ctrl};
            1:       return m_preset;
            2:       return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1 v = rdata;
    endtask

    // One bus cycle, then every register and irq is compared with the model.
    task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d, input string tag);
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        model_edge(w, a, d);
        #1 we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr = i[1:0];
            #1 check($sformatf("%s rd%0d t%0d", tag, i, m_t), rdata, exp_rd(i));
        end
        check($sformatf("%s irq t%0d", tag, m_t), {31'd0, irq}, {31'd0, m_ctrl[3] & m_pend});
    endtask

    initial begin
        logic [31:0] v;
        int highs;
        clr   = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = 32'd0;
        model_reset();
        #2;
        for (int i = 0; i < 4; i++) begin
            rd(i[1:0], v);
            check($sformatf("reset rd%0d", i), v, 32'd0);
        end
        check("reset irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        clr = 1'b0;

        // One-shot, PRESET = 5
        step(1'b1, 2'd1, 32'd5, "os_pre");
        step(1'b1, 2'd0, 32'h9, "os_e0");
        for (int j = 1; j <= 9; j++) begin
            step(1'b0, 2'd0, 32'd0, "os");
            if (j >= 2 && j <= 7) begin
                rd(2'd2, v);
                check($sformatf("os_count e%0d", j), v, 32'(7 - j));
            end
            if (j == 8) check("os_irq_rise", {31'd0, irq}, 32'd1);
            if (j == 9) begin
                rd(2'd0, v);
                check("os_ctrl_en_clr", v, 32'h8);
                check("os_irq_held", {31'd0, irq}, 32'd1);
            end
        end
        step(1'b1, 2'd0, 32'h8, "os_ack");
        check("os_irq_ack", {31'd0, irq}, 32'd0);

        // Asynchronous reset mid-count
        step(1'b1, 2'd1, 32'd5, "rst_pre");
        step(1'b1, 2'd0, 32'h9, "rst_en");
        for (int j = 0; j < 4; j++) step(1'b0, 2'd0, 32'd0, "rst_run");
        #2 clr = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            rd(i[1:0], v);
            check($sformatf("midreset rd%0d", i), v, 32'd0);
        end
        check("midreset irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        for (int j = 0; j < 4; j++) step(1'b0, 2'd0, 32'd0, "post_rst");
        rd(2'd2, v);
        check("post_rst count", v, 32'd0);

        // Auto-reload, PRESET = 2: one-cycle pulse every 5 edges
        step(1'b1, 2'd1, 32'd2, "ar_pre");
        step(1'b1, 2'd0, 32'hB, "ar_en");
        highs = 0;
        for (int j = 1; j <= 20; j++) begin
            step(1'b0, 2'd0, 32'd0, "ar");
            if (irq) highs++;
            if (j % 5 == 0) check($sformatf("ar_pulse e%0d", j), {31'd0, irq}, 32'd1);
            if (j % 5 == 2) begin
                rd(2'd2, v);
                check($sformatf("ar_reload e%0d", j), v, 32'd2);
            end
        end
        check("ar_high_cycles", 32'(highs), 32'd4);
        step(1'b1, 2'd0, 32'h0, "ar_off");
        for (int j = 0; j < 4; j++) step(1'b0, 2'd0, 32'd0, "ar_idle");

        // Masked interrupt with PRESET = 0, then unmasked
        step(1'b1, 2'd1, 32'd0, "mk_pre");
        step(1'b1, 2'd0, 32'h1, "mk_en");
        for (int j = 1; j <= 4; j++) step(1'b0, 2'd0, 32'd0, "mk");
        rd(2'd0, v);
        check("mk_en_cleared", v, 32'h0);
        step(1'b1, 2'd0, 32'h9, "mk_unmask");
        for (int j = 1; j <= 3; j++) step(1'b0, 2'd0, 32'd0, "mk2");
        check("mk_irq_3edges", {31'd0, irq}, 32'd1);
        step(1'b1, 2'd0, 32'h0, "mk_off");

        // Disable mid-count, change PRESET, re-enable
        step(1'b1, 2'd1, 32'd10, "dis_pre");
        step(1'b1, 2'd0, 32'h1, "dis_en");
        for (int j = 1; j <= 5; j++) step(1'b0, 2'd0, 32'd0, "dis_run");
        step(1'b1, 2'd0, 32'h0, "dis_off");
        rd(2'd2, v);
        check("dis_count6", v, 32'd6);
        for (int j = 0; j < 3; j++) step(1'b0, 2'd0, 32'd0, "dis_hold");
        rd(2'd2, v);
        check("dis_count_held", v, 32'd6);
        step(1'b1, 2'd1, 32'd3, "dis_newpre");
        step(1'b1, 2'd0, 32'h9, "dis_reen");
        for (int j = 1; j <= 6; j++) begin
            step(1'b0, 2'd0, 32'd0, "dis_re");
            if (j == 2) begin
                rd(2'd2, v);
                check("dis_reload3", v, 32'd3);
            end
            if (j == 5) check("dis_irq_early", {31'd0, irq}, 32'd0);
            if (j == 6) check("dis_irq_6edges", {31'd0, irq}, 32'd1);
        end
        step(1'b1, 2'd0, 32'h0, "dis_ack");

        // Bus decode
        step(1'b1, 2'd2, 32'h1234_5678, "bus_wcount");
        step(1'b1, 2'd3, 32'hFFFF_FFFF, "bus_w3");
        rd(2'd3, v);
        check("bus_addr3_zero", v, 32'd0);
        step(1'b1, 2'd0, 32'hFFFF_FFFF, "bus_ctrl_ff");
        rd(2'd0, v);
        check("bus_ctrl_0xF", v, 32'hF);
        step(1'b1, 2'd0, 32'h0, "bus_off");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic        w;
            logic [1:0]  a;
            logic [31:0] d;
            w = ($urandom_range(0, 7) == 0);
            a = 2'($urandom_range(0, 3));
            d = (a == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
            step(w, a, d, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
